// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: opcode map, FSM states and default width.
package alu_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_AND  = 4'b0010,
    OP_OR   = 4'b0011,
    OP_XOR  = 4'b0100,
    OP_SLL  = 4'b0101,
    OP_SRL  = 4'b0110,
    OP_SRA  = 4'b0111,
    OP_SLT  = 4'b1000,
    OP_SLTU = 4'b1001,
    OP_MULU = 4'b1010,
    OP_DIVU = 4'b1011
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_muldiv_iter.sv
// One-bit-per-cycle unsigned multiply (shift-add) and restoring divide.
// Both ops start from {hi,lo} = {0,a}; the first step runs on the start edge itself.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam logic [SHW:0] LAST_CNT = (SHW+1)'(WIDTH);
  localparam logic [SHW:0] ONE_CNT  = (SHW+1)'(1);

  logic [SHW:0]     r_cnt;
  logic             r_op;
  logic [WIDTH-1:0] r_hi, r_lo, r_opnd;

  logic             w_step, w_op;
  logic [WIDTH-1:0] w_src_hi, w_src_lo, w_src_opnd;
  logic [WIDTH:0]   w_sum, w_trial;
  logic [WIDTH-1:0] w_nxt_hi, w_nxt_lo;

  // The counter parks at LAST_CNT when an op completes, so done is a level until the next start.
  assign w_step     = start || (r_cnt != '0 && r_cnt != LAST_CNT);
  assign w_op       = start ? op : r_op;
  assign w_src_hi   = start ? '0 : r_hi;
  assign w_src_lo   = start ? a  : r_lo;
  assign w_src_opnd = start ? b  : r_opnd;

  assign w_sum   = {1'b0, w_src_hi} + (w_src_lo[0] ? {1'b0, w_src_opnd} : '0);
  assign w_trial = {w_src_hi, w_src_lo[WIDTH-1]} - {1'b0, w_src_opnd};

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    w_nxt_hi = {w_sum[WIDTH:1]};
    w_nxt_lo = {w_sum[0], w_src_lo[WIDTH-1:1]};
    if (w_op) begin
      if (!w_trial[WIDTH]) begin
        w_nxt_hi = w_trial[WIDTH-1:0];
        w_nxt_lo = {w_src_lo[WIDTH-2:0], 1'b1};
      end else begin
        w_nxt_hi = {w_src_hi[WIDTH-2:0], w_src_lo[WIDTH-1]};
        w_nxt_lo = {w_src_lo[WIDTH-2:0], 1'b0};
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_op   <= 1'b0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_opnd <= '0;
    end else if (w_step) begin
      r_cnt  <= start ? ONE_CNT : r_cnt + ONE_CNT;
      r_op   <= w_op;
      r_hi   <= w_nxt_hi;
      r_lo   <= w_nxt_lo;
      r_opnd <= w_src_opnd;
    end
  end

  assign done = (r_cnt == LAST_CNT);
  assign lo   = r_lo;
  assign hi   = r_hi;

endmodule

// File: rtl/mc_alu.sv
// Multi-cycle ALU: single-cycle ops resolve at accept, MULU/DIVU run in alu_muldiv_iter.
// Results are registered and held in DONE until the consumer takes them.
module mc_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             ovf,
  output logic             dbz
);

  alu_state_e r_state, w_next_state;

  logic [WIDTH-1:0] r_result, r_result_hi;
  logic             r_zero, r_ovf, r_dbz;

  logic             w_accept, w_is_mulu, w_is_divu, w_iter, w_start;
  logic [SHW-1:0]   w_shamt;
  logic [WIDTH-1:0] w_sum, w_diff;
  logic [WIDTH-1:0] w_sc_res, w_sc_hi;
  logic             w_sc_ovf, w_sc_dbz, w_sc_legal, w_sc_zero;
  logic             w_md_done;
  logic [WIDTH-1:0] w_md_lo, w_md_hi;

  assign w_accept  = in_valid && (r_state == ST_IDLE);
  assign w_is_mulu = (alu_control == OP_MULU);
  assign w_is_divu = (alu_control == OP_DIVU);
  // Divide by zero bypasses the iterative unit and completes like a single-cycle op.
  assign w_iter    = w_is_mulu || (w_is_divu && b != '0);
  assign w_start   = w_accept && w_iter;

  assign w_shamt = b[SHW-1:0];
  assign w_sum   = a + b;
  assign w_diff  = a - b;

  always_comb begin
    w_sc_res   = '0;
    w_sc_hi    = '0;
    w_sc_ovf   = 1'b0;
    w_sc_dbz   = 1'b0;
    w_sc_legal = 1'b1;
    case (alu_control)
      OP_ADD: begin
        w_sc_res = w_sum;
        w_sc_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        w_sc_res = w_diff;
        w_sc_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  w_sc_res = a & b;
      OP_OR:   w_sc_res = a | b;
      OP_XOR:  w_sc_res = a ^ b;
      OP_SLL:  w_sc_res = a << w_shamt;
      OP_SRL:  w_sc_res = a >> w_shamt;
      OP_SRA:  w_sc_res = $signed(a) >>> w_shamt;
      OP_SLT:  w_sc_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: w_sc_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_DIVU: begin
        w_sc_res = '1;
        w_sc_hi  = a;
        w_sc_dbz = 1'b1;
      end
      default: w_sc_legal = 1'b0;
    endcase
  end

  // Reserved opcodes report all flags clear, including zero.
  assign w_sc_zero = w_sc_legal && (w_sc_res == '0);

  alu_muldiv_iter #(
    .WIDTH(WIDTH),
    .SHW  (SHW)
  ) u_muldiv (
    .clk  (clk),
    .reset(reset),
    .start(w_start),
    .op   (w_is_divu),
    .a    (a),
    .b    (b),
    .done (w_md_done),
    .lo   (w_md_lo),
    .hi   (w_md_hi)
  );

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (in_valid) w_next_state = w_iter ? ST_BUSY : ST_DONE;
      ST_BUSY: if (w_md_done) w_next_state = ST_DONE;
      ST_DONE: if (out_ready) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_result    <= '0;
      r_result_hi <= '0;
      r_zero      <= 1'b0;
      r_ovf       <= 1'b0;
      r_dbz       <= 1'b0;
    end else if (w_accept && !w_iter) begin
      r_result    <= w_sc_res;
      r_result_hi <= w_sc_hi;
      r_zero      <= w_sc_zero;
      r_ovf       <= w_sc_ovf;
      r_dbz       <= w_sc_dbz;
    end else if (r_state == ST_BUSY && w_md_done) begin
      r_result    <= w_md_lo;
      r_result_hi <= w_md_hi;
      r_zero      <= (w_md_lo == '0);
      r_ovf       <= 1'b0;
      r_dbz       <= 1'b0;
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign result    = r_result;
  assign result_hi = r_result_hi;
  assign zero      = r_zero;
  assign ovf       = r_ovf;
  assign dbz       = r_dbz;

endmodule
